// File: rtl/icache_param.sv
`default_nettype none
// ============================================================================
// Module  : icache_param
// Purpose : N-way set-associative instruction cache with tree-PLRU, uncached
//           bypass and full invalidate sweep; one 32-bit word per hit.
// Rev     : 1.0  initial release
// ============================================================================
module icache_param #(
  parameter int WAYS       = 4,
  parameter int SETS       = 128,
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic                     cpu_uncached,
  input  logic                     inv_req,
  output logic                     stall,
  output logic                     rd_valid,
  output logic [31:0]              rd_data,
  output logic                     axi_rd_req,
  output logic [ADDR_W-1:0]        axi_addr,
  input  logic                     axi_gnt,
  input  logic [32*LINE_WORDS-1:0] axi_data
);
  localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int PLRU_W = WAYS - 1;

  localparam logic [2:0] c_INV    = 3'd0;
  localparam logic [2:0] c_IDLE   = 3'd1;
  localparam logic [2:0] c_LOOKUP = 3'd2;
  localparam logic [2:0] c_REQ    = 3'd3;
  localparam logic [2:0] c_REFILL = 3'd4;

  logic [2:0]                   r_state;
  logic [IDX_W-1:0]             r_sweep;
  logic                         r_inv_pend;
  logic [TAG_W-1:0]             r_tag;
  logic [IDX_W-1:0]             r_idx;
  logic [WSEL_W-1:0]            r_wsel;
  logic                         r_unc;
  logic [LINE_WORDS-1:0][31:0]  r_line;
  logic [WAYS-1:0]              r_valid [SETS];
  logic [PLRU_W-1:0]            r_plru  [SETS];

  logic                         w_accept;
  logic                         w_hit;
  logic                         w_fill;
  logic [WAYS-1:0]              w_hit_vec;
  logic [WAYS-1:0][31:0]        w_way_word;
  logic [WAY_W-1:0]             w_hit_way;
  logic [31:0]                  w_hit_word;
  logic [WAY_W-1:0]             w_victim;
  logic                         w_found;
  logic                         w_unused;

  assign w_unused = &{1'b0, cpu_addr[1:0]};

  // Tree bits: 0 means the victim lies in the left subtree (node n -> 2n+1, 2n+2).
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] t);
    int n;
    n = 0;
    for (int l = 0; l < WAY_W; l++) n = 2 * n + 1 + int'(t[n]);
    return WAY_W'(n - PLRU_W);
  endfunction

  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] t,
                                                   input logic [WAY_W-1:0]  w);
    logic [PLRU_W-1:0] r;
    logic              d;
    int                n;
    r = t;
    n = 0;
    for (int l = 0; l < WAY_W; l++) begin
      d    = w[WAY_W-1-l];
      r[n] = ~d;
      n    = 2 * n + 1 + int'(d);
    end
    return r;
  endfunction

  assign w_fill = (r_state == c_REFILL) && !r_unc && !rst;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [TAG_W-1:0]            r_mem_tag  [SETS];
    logic [LINE_WORDS-1:0][31:0] r_mem_data [SETS];
    logic [TAG_W-1:0]            r_rtag;
    logic [LINE_WORDS-1:0][31:0] r_rdata;

    always_ff @(posedge clk) begin
      if (w_fill && w_victim == WAY_W'(w)) begin
        r_mem_tag[r_idx]  <= r_tag;
        r_mem_data[r_idx] <= r_line;
      end
      if (w_accept) begin
        r_rtag  <= r_mem_tag[cpu_addr[OFF_W +: IDX_W]];
        r_rdata <= r_mem_data[cpu_addr[OFF_W +: IDX_W]];
      end
    end

    assign w_hit_vec[w]  = r_valid[r_idx][w] && (r_rtag == r_tag);
    assign w_way_word[w] = r_rdata[r_wsel];
  end

  assign w_hit = (r_state == c_LOOKUP) && !r_unc && (|w_hit_vec);

  always_comb begin
    w_hit_way  = '0;
    w_hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_hit_vec[w]) begin
        w_hit_way  = WAY_W'(w);
        w_hit_word = w_way_word[w];
      end
    end
  end

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    w_victim = '0;
    w_found  = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[r_idx][w]) begin
        w_victim = WAY_W'(w);
        w_found  = 1'b1;
      end
    end
    if (!w_found) w_victim = plru_victim(r_plru[r_idx]);
  end

  always_comb begin
    case (r_state)
      c_IDLE:   stall = inv_req;
      c_LOOKUP: stall = !w_hit || r_inv_pend || inv_req;
      default:  stall = 1'b1;
    endcase
  end

  assign w_accept   = cpu_req && !stall && (r_state == c_IDLE || r_state == c_LOOKUP);
  assign rd_valid   = w_hit || (r_state == c_REFILL);
  assign rd_data    = (r_state == c_REFILL) ? r_line[r_wsel] : (w_hit ? w_hit_word : 32'd0);
  assign axi_rd_req = (r_state == c_REQ);
  assign axi_addr   = {r_tag, r_idx, {OFF_W{1'b0}}};

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == c_INV) begin
        r_valid[r_sweep] <= '0;
        r_plru[r_sweep]  <= '0;
      end else if (w_fill) begin
        r_valid[r_idx][w_victim] <= 1'b1;
        r_plru[r_idx]            <= plru_touch(r_plru[r_idx], w_victim);
      end else if (w_hit) begin
        r_plru[r_idx] <= plru_touch(r_plru[r_idx], w_hit_way);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_tag  <= cpu_addr[ADDR_W-1 -: TAG_W];
      r_idx  <= cpu_addr[OFF_W +: IDX_W];
      r_wsel <= cpu_addr[OFF_W-1:2];
      r_unc  <= cpu_uncached;
    end
    if (r_state == c_REQ && axi_gnt) r_line <= axi_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_INV;
      r_sweep    <= '0;
      r_inv_pend <= 1'b0;
    end else begin
      case (r_state)
        c_INV: begin
          if (inv_req) begin
            r_sweep <= '0;
          end else begin
            r_sweep <= r_sweep + 1'b1;
            if (r_sweep == IDX_W'(SETS - 1)) r_state <= c_IDLE;
          end
        end
        c_IDLE: begin
          if (inv_req) begin
            r_state <= c_INV;
            r_sweep <= '0;
          end else if (w_accept) begin
            r_state <= c_LOOKUP;
          end
        end
        c_LOOKUP: begin
          r_inv_pend <= r_inv_pend | inv_req;
          if (!w_hit) begin
            r_state <= c_REQ;
          end else if (r_inv_pend || inv_req) begin
            r_state    <= c_INV;
            r_sweep    <= '0;
            r_inv_pend <= 1'b0;
          end else if (w_accept) begin
            r_state <= c_LOOKUP;
          end else begin
            r_state <= c_IDLE;
          end
        end
        c_REQ: begin
          r_inv_pend <= r_inv_pend | inv_req;
          if (axi_gnt) r_state <= c_REFILL;
        end
        c_REFILL: begin
          if (r_inv_pend || inv_req) begin
            r_state    <= c_INV;
            r_sweep    <= '0;
            r_inv_pend <= 1'b0;
          end else begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_INV;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && r_state == c_LOOKUP) assert ($onehot0(w_hit_vec));
  end
`endif

endmodule
`default_nettype wire
